fetch_seq_ctrl: RTL and testbench



---
 rtl/fetch_seq_ctrl_pkg.sv | 33 +++
 rtl/fetch_seq_ctrl_buf.sv | 67 ++++++
 rtl/fetch_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl_pkg
// Brief    : Shared types and constants for the fetch-stage sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_seq_ctrl_pkg;

    // Instruction and address width.
    localparam int c_XLEN = 32;

    // Default fetch address after reset.
    localparam logic [c_XLEN-1:0] c_RESET_PC = 32'h0000_0000;

    // Sequencer states. FETCH and DROP both own an outstanding request;
    // DROP means its response is stale and will be thrown away.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DROP  = 2'd2;

    // One instruction-buffer entry: fetch address plus fetched word.
    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] ins;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [c_XLEN-1:0] word_align(input logic [c_XLEN-1:0] addr);
        return {addr[c_XLEN-1:2], 2'b00};
    endfunction

endpackage : fetch_seq_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_seq_ctrl_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Brief    : DEPTH-entry synchronous FIFO of {pc, ins} between fetch and
//            decode, with single-cycle flush. Head outputs come straight
//            from storage (no bypass from the write port) and read as zero
//            while the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buf
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               push_data,
    output logic                       head_valid,
    output fetch_entry_t               head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam int              c_CW   = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // Circular increment that also handles non-power-of-two depths.
    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + c_CW'(push) - c_CW'(pop);
        end
    end

    // Entry storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clock) begin
        if (push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_valid = (r_count != '0);
    assign head_data  = head_valid ? r_mem[r_rd_ptr] : '0;
    assign count      = r_count;

endmodule : fetch_buf
`default_nettype wire

// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl
// Brief    : Fetch-stage sequencer. Owns the PC, issues one outstanding
//            req/ack read at a time to instruction memory, buffers fetched
//            words toward decode, and discards in-flight responses that a
//            redirect has made stale.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect,
    input  logic [c_XLEN-1:0] redirect_pc,
    output logic              mem_req,
    output logic [c_XLEN-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [c_XLEN-1:0] mem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [c_XLEN-1:0] id_ins,
    output logic [c_XLEN-1:0] id_pc,
    output logic [c_XLEN-1:0] id_pc4
);

    localparam int              c_CW        = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_XLEN-1:0] r_pc;
    logic [c_XLEN-1:0] r_drop_addr;
    logic [c_XLEN-1:0] w_target;
    logic              w_push;
    logic              w_pop;
    logic [c_CW-1:0]   w_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic              w_head_valid;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;

    assign w_target    = word_align(redirect_pc);

    // Only a live (non-stale) response is buffered; a redirect the same
    // cycle turns it stale and also cancels any pop.
    assign w_push      = (r_state == c_ST_FETCH) && mem_ack && !redirect;
    assign w_pop       = w_head_valid && id_ready && !redirect;
    assign w_push_data = '{pc: r_pc, ins: mem_rdata};

    // Occupancy after this cycle's push/pop, used to decide whether the
    // next back-to-back request still has a free slot to land in.
    assign w_count_nxt = w_count + c_CW'(w_push) - c_CW'(w_pop);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: credit gating, stale-response tracking and redirect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // Nothing in flight here, so credit is just buffer room.
                if (redirect || (w_count < c_DEPTH_CNT)) w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (mem_ack) begin
                    if (redirect)                       w_state_nxt = c_ST_FETCH;
                    else if (w_count_nxt < c_DEPTH_CNT) w_state_nxt = c_ST_FETCH;
                    else                                w_state_nxt = c_ST_IDLE;
                end else if (redirect) begin
                    w_state_nxt = c_ST_DROP;
                end
            end
            c_ST_DROP: begin
                // Buffer was flushed on entry, so the restart always has room.
                if (mem_ack) w_state_nxt = c_ST_FETCH;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: the request is held stable until acknowledged.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        case (r_state)
            c_ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
            end
            c_ST_DROP: begin
                mem_req  = 1'b1;
                mem_addr = r_drop_addr;
            end
            default: begin
                mem_req  = 1'b0;
                mem_addr = '0;
            end
        endcase
    end

    // PC: last redirect target wins; otherwise advance per buffered word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_pc <= RESET_PC;
        else if (redirect) r_pc <= w_target;
        else if (w_push)   r_pc <= r_pc + 32'd4;
    end

    // Remember the abandoned address so mem_addr stays put while the PC
    // already points at the redirect target.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_addr <= '0;
        end else if ((r_state == c_ST_FETCH) && redirect && !mem_ack) begin
            r_drop_addr <= r_pc;
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_fetch_buf (
        .clock      (clock),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (redirect),
        .push_data  (w_push_data),
        .head_valid (w_head_valid),
        .head_data  (w_head),
        .count      (w_count)
    );

    assign id_valid = w_head_valid;
    assign id_ins   = w_head.ins;
    assign id_pc    = w_head.pc;
    assign id_pc4   = w_head_valid ? (w_head.pc + 32'd4) : '0;

endmodule : fetch_seq_ctrl
`default_nettype wire

// File: tb/tb_fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq_ctrl
// Brief    : Self-checking bench for fetch_seq_ctrl. A transaction-level
//            model (pending request + queue of buffered words) predicts the
//            outputs each cycle; directed phases pin it with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq_ctrl;

    localparam logic [31:0] c_RPC   = 32'hFFFF_FFF8;
    localparam int          c_DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        id_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    always #5 clock = ~clock;

    fetch_seq_ctrl #(
        .RESET_PC (c_RPC),
        .DEPTH    (c_DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_ins      (id_ins),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Model: words waiting for decode, the one outstanding request (if any),
    // whether its response is stale, and the next fetch address.
    ent_t        mq[$];
    bit          m_busy;
    bit          m_stale;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    int          req_wait;
    int          lat_mode;
    bit          spur_en;
    bit          chk_en;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int pick_lat();
        return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy   = 1'b0;
        m_stale  = 1'b0;
        m_pc     = c_RPC;
        m_addr   = '0;
        req_wait = 0;
    endtask

    // Advance the model by one clock using the inputs held during the cycle.
    task automatic model_step();
        bit          ack;
        bit          push;
        bit          pop;
        bit          issue;
        int          cnt_before;
        logic [31:0] tgt;
        ack        = m_busy && mem_ack;
        pop        = (mq.size() > 0) && id_ready && !redirect;
        push       = ack && !m_stale && !redirect;
        tgt        = {redirect_pc[31:2], 2'b00};
        cnt_before = mq.size();
        if (redirect) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back('{pc: m_addr, ins: mem_rdata});
        end
        if (redirect)  m_pc = tgt;
        else if (push) m_pc = m_pc + 32'd4;
        if (m_busy && !ack) begin
            if (redirect) m_stale = 1'b1;
            if (req_wait > 0) req_wait--;
        end else begin
            if (redirect)               issue = 1'b1;
            else if (m_busy && m_stale) issue = 1'b1;
            else if (m_busy)            issue = (mq.size() < c_DEPTH);
            else                        issue = (cnt_before < c_DEPTH);
            m_busy  = issue;
            m_stale = 1'b0;
            if (issue) begin
                m_addr   = m_pc;
                req_wait = pick_lat();
            end
        end
    endtask

    // Memory: answer the outstanding request after its chosen wait, and
    // optionally throw in acks while nothing is requested.
    task automatic drive_mem();
        if (m_busy) begin
            mem_ack   = (req_wait == 0);
            mem_rdata = mem_ack ? word_of(m_addr) : $urandom;
        end else begin
            mem_ack   = spur_en && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (!reset) model_step();
        drive_mem();
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
            if (m_busy) chk("mem_addr", mem_addr, m_addr);
            chk("id_valid", {31'd0, id_valid}, {31'd0, (mq.size() > 0)});
            if (mq.size() > 0) begin
                chk("id_pc",  id_pc,  mq[0].pc);
                chk("id_ins", id_ins, mq[0].ins);
                chk("id_pc4", id_pc4, mq[0].pc + 32'd4);
            end
        end
    end

    initial begin
        int          na;
        int          nack;
        int          w;
        bit          got;
        bit          got_v;
        logic [31:0] seen [3];
        logic [31:0] pc4_second;
        logic [31:0] next_addr;
        logic [31:0] first_v_pc;

        lat_mode = 0;
        spur_en  = 1'b0;
        chk_en   = 1'b0;
        model_reset();
        seen[0] = '1; seen[1] = '1; seen[2] = '1;
        pc4_second = '1;

        // Reset values.
        repeat (2) @(posedge clock);
        #2;
        chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("rst_mem_addr", mem_addr,          32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_ins",   id_ins,            32'd0);
        chk("rst_id_pc",    id_pc,             32'd0);
        chk("rst_id_pc4",   id_pc4,            32'd0);
        @(negedge clock);
        reset    = 1'b0;
        chk_en   = 1'b1;
        id_ready = 1'b1;

        // Zero-wait memory from a reset PC just below the wrap point.
        na  = 0;
        got = 1'b0;
        repeat (8) begin
            step();
            if (mem_req && na < 3) begin
                seen[na] = mem_addr;
                na++;
            end
            if (id_valid && id_pc == 32'hFFFF_FFFC && !got) begin
                pc4_second = id_pc4;
                got = 1'b1;
            end
        end
        chk("wrap_addr0", seen[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", seen[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", seen[2], 32'h0000_0000);
        chk("wrap_pc4",   pc4_second, 32'h0000_0000);

        // 3-cycle memory with decode stalled: only two words fit.
        lat_mode    = 2;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0003;
        id_ready    = 1'b0;
        step();
        redirect = 1'b0;
        nack = 0;
        repeat (14) begin
            if (mem_req && mem_ack) nack++;
            step();
        end
        chk("stall_nack",  32'(nack), 32'd2);
        chk("stall_req",   {31'd0, mem_req},  32'd0);
        chk("stall_valid", {31'd0, id_valid}, 32'd1);
        chk("stall_pc",    id_pc, 32'd0);

        // Decode resumes; fetch continues at 8.
        id_ready = 1'b1;
        w = 0;
        step();
        while (!mem_req && w < 10) begin
            step();
            w++;
        end
        chk("resume_req",  {31'd0, mem_req}, 32'd1);
        chk("resume_addr", mem_addr, 32'h0000_0008);

        // Redirect while the request to 8 still has two cycles to go.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0;
        chk("drop_hold", mem_addr, 32'h0000_0008);
        got        = 1'b0;
        got_v      = 1'b0;
        next_addr  = '1;
        first_v_pc = '1;
        repeat (20) begin
            if (mem_req && mem_addr != 32'h8 && !got) begin
                got = 1'b1;
                next_addr = mem_addr;
            end
            if (id_valid && !got_v) begin
                got_v = 1'b1;
                first_v_pc = id_pc;
            end
            step();
        end
        chk("drop_next_addr", next_addr,  32'h0000_0040);
        chk("drop_first_pc",  first_v_pc, 32'h0000_0040);

        // Redirect coinciding with an ack and an attempted pop.
        lat_mode = 1;
        id_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_busy && req_wait == 0 && mq.size() >= 1) begin
                got = 1'b1;
                break;
            end
        end
        chk("ackredir_found", {31'd0, got}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0101;
        id_ready    = 1'b1;
        step();
        redirect = 1'b0;
        chk("ackredir_valid", {31'd0, id_valid}, 32'd0);
        chk("ackredir_req",   {31'd0, mem_req},  32'd1);
        chk("ackredir_addr",  mem_addr, 32'h0000_0100);
        w = 0;
        while (!id_valid && w < 10) begin
            step();
            w++;
        end
        chk("ackredir_pc",  id_pc,  32'h0000_0100);
        chk("ackredir_ins", id_ins, word_of(32'h0000_0100));

        // Randomized traffic.
        lat_mode = -1;
        spur_en  = 1'b1;
        repeat (3000) begin
            step();
            redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           redirect_pc = $urandom;
            id_ready = ($urandom_range(0, 2) != 0);
        end

        // Reset in the middle of a request.
        redirect = 1'b0;
        spur_en  = 1'b0;
        id_ready = 1'b1;
        w = 0;
        step();
        while (!m_busy && w < 20) begin
            step();
            w++;
        end
        #1;
        reset   = 1'b1;
        mem_ack = 1'b0;
        #1;
        chk("midrst_req",   {31'd0, mem_req},  32'd0);
        chk("midrst_valid", {31'd0, id_valid}, 32'd0);
        model_reset();
        step();
        step();
        #1;
        reset = 1'b0;
        w = 0;
        step();
        while (!mem_req && w < 6) begin
            step();
            w++;
        end
        chk("midrst_restart", mem_addr, c_RPC);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_seq_ctrl
`default_nettype wire
